btb_updater: RTL and testbench

- Sits at the branch-resolution end of the pipeline (EX/MEM boundary) and forms the write side of the branch target buffer.
- Takes each resolved control-flow instruction together with the prediction that fetch made for it.
- Raises a one-cycle redirect on a mispredict and computes the new BTB entry (2-bit counter plus target).
- Buffers entry updates in a small FIFO and drains them into the BTB write port, deferring any write that collides with the set fetch is currently reading.

---
 rtl/btb_updater.sv | 171 +++++++++++++++++
 tb/tb_btb_updater.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_updater.sv
// Write side of the branch target buffer: checks resolved control flow against the
// fetch-time prediction, raises refetch redirects and queues counter/target updates.
module btb_updater #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned S_INDEX   = 3,
    parameter logic [1:0]  CTR_INIT  = 2'b10,
    parameter int unsigned DEFER_MAX = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      res_valid,
    output logic                      res_ready,
    input  logic [31:0]               res_pc,
    input  logic                      res_is_br,
    input  logic                      res_taken,
    input  logic [31:0]               res_target,
    input  logic                      pred_hit,
    input  logic [1:0]                pred_ctr,
    input  logic [31:0]               pred_target,
    input  logic [31:0]               fetch_raddr,
    output logic                      redirect,
    output logic [31:0]               redirect_pc,
    output logic                      btb_load,
    output logic [31:0]               btb_waddr,
    output logic [33:0]               btb_wdata,
    output logic [31:0]               mispredict_count,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned DW = (DEFER_MAX > 0) ? $clog2(DEFER_MAX + 1) : 1;

    logic [31:0]   fifo_pc_q  [DEPTH];
    logic [1:0]    fifo_ctr_q [DEPTH];
    logic [31:0]   fifo_tgt_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] defer_q, defer_d;
    logic          redirect_q, redirect_d;
    logic [31:0]   redirect_pc_q, redirect_pc_d;
    logic [31:0]   mis_cnt_q, mis_cnt_d;

    logic          accept;
    logic          pred_taken;
    logic          mispredict;
    logic          upd_valid;
    logic [1:0]    upd_ctr;
    logic [31:0]   upd_tgt;
    logic          redundant;
    logic          push;
    logic          pop;
    logic [S_INDEX-1:0] head_idx;
    logic [S_INDEX-1:0] fetch_idx;
    logic          unused_ok;

    assign accept     = res_valid && res_ready;
    assign pred_taken = pred_hit && pred_ctr[1];
    assign mispredict = (res_taken != pred_taken) ||
                        (res_taken && pred_taken && (res_target != pred_target));

    // Jumps always allocate strongly taken; a cold not-taken branch leaves the BTB untouched.
    always_comb begin
        upd_valid = 1'b1;
        upd_ctr   = 2'b11;
        upd_tgt   = res_target;
        if (res_is_br) begin
            if (pred_hit) begin
                if (res_taken) begin
                    upd_ctr = (pred_ctr == 2'b11) ? 2'b11 : pred_ctr + 2'd1;
                    upd_tgt = res_target;
                end else begin
                    upd_ctr = (pred_ctr == 2'b00) ? 2'b00 : pred_ctr - 2'd1;
                    upd_tgt = pred_target;
                end
            end else if (res_taken) begin
                upd_ctr = CTR_INIT;
                upd_tgt = res_target;
            end else begin
                upd_valid = 1'b0;
            end
        end
    end

    assign redundant = pred_hit && (upd_ctr == pred_ctr) && (upd_tgt == pred_target);
    assign push      = accept && upd_valid && !redundant;

    assign head_idx  = fifo_pc_q[head_q][S_INDEX+1:2];
    assign fetch_idx = fetch_raddr[S_INDEX+1:2];

    // A write into the set fetch is reading is held back, but only for DEFER_MAX cycles.
    assign btb_load  = (count_q != '0) &&
                       ((head_idx != fetch_idx) || (defer_q == DW'(DEFER_MAX)));
    assign pop       = btb_load;

    assign res_ready = count_q < CW'(DEPTH);
    assign btb_waddr = fifo_pc_q[head_q];
    assign btb_wdata = {fifo_ctr_q[head_q], fifo_tgt_q[head_q]};
    assign occupancy = count_q;

    assign redirect         = redirect_q;
    assign redirect_pc      = redirect_pc_q;
    assign mispredict_count = mis_cnt_q;

    assign unused_ok = ^{fetch_raddr[31:S_INDEX+2], fetch_raddr[1:0]};

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        defer_d       = defer_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        mis_cnt_d     = mis_cnt_q;

        if (push) begin
            tail_d = tail_q + PW'(1);
        end
        if (pop) begin
            head_d  = head_q + PW'(1);
            defer_d = '0;
        end else if (count_q != '0) begin
            defer_d = defer_q + DW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (accept && mispredict) begin
            redirect_d    = 1'b1;
            redirect_pc_d = res_taken ? res_target : res_pc + 32'd4;
            if (mis_cnt_q != 32'hFFFF_FFFF) begin
                mis_cnt_d = mis_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            defer_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            mis_cnt_q     <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            defer_q       <= defer_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            mis_cnt_q     <= mis_cnt_d;
        end
    end

    // Entry storage needs no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[tail_q]  <= res_pc;
            fifo_ctr_q[tail_q] <= upd_ctr;
            fifo_tgt_q[tail_q] <= upd_tgt;
        end
    end

endmodule

// File: tb/tb_btb_updater.sv
// Scoreboard bench for btb_updater: expected BTB writes and redirects are queued at accept
// time and compared against the DUT outputs sampled on the falling clock edge.
module tb_btb_updater;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  ctr;
        logic [31:0] tgt;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_pc;
    logic        res_is_br;
    logic        res_taken;
    logic [31:0] res_target;
    logic        pred_hit;
    logic [1:0]  pred_ctr;
    logic [31:0] pred_target;
    logic [31:0] fetch_raddr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        btb_load;
    logic [31:0] btb_waddr;
    logic [33:0] btb_wdata;
    logic [31:0] mispredict_count;
    logic [2:0]  occupancy;

    entry_t      expQ[$];
    logic        expRedir;
    logic [31:0] expRedirPc;
    logic [31:0] expMis;
    int          waitCnt;
    bit          monOn;
    int          checkCount;
    int          passCount;

    btb_updater #(
        .DEPTH(4), .S_INDEX(3), .CTR_INIT(2'b10), .DEFER_MAX(3)
    ) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_pc(res_pc), .res_is_br(res_is_br), .res_taken(res_taken),
        .res_target(res_target), .pred_hit(pred_hit), .pred_ctr(pred_ctr),
        .pred_target(pred_target), .fetch_raddr(fetch_raddr),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .btb_load(btb_load), .btb_waddr(btb_waddr), .btb_wdata(btb_wdata),
        .mispredict_count(mispredict_count), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        else
            passCount++;
    endtask

    function automatic logic [2:0] setOf(input logic [31:0] a);
        return a[4:2];
    endfunction

    // Record what the DUT should do for a transaction that was just accepted.
    task automatic recordAccepted(input logic [31:0] pc, input logic isBr, input logic taken,
                                  input logic [31:0] tgt, input logic hit,
                                  input logic [1:0] ctr, input logic [31:0] ptgt);
        logic   predTaken;
        logic   wrong;
        logic   doWrite;
        entry_t e;
        predTaken = hit && (ctr >= 2'b10);
        wrong = 1'b0;
        if (taken != predTaken) wrong = 1'b1;
        if (taken && predTaken && tgt != ptgt) wrong = 1'b1;
        doWrite = 1'b1;
        e.pc  = pc;
        e.ctr = 2'b11;
        e.tgt = tgt;
        if (isBr && hit && taken) begin
            e.ctr = (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
        end else if (isBr && hit && !taken) begin
            e.ctr = (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
            e.tgt = ptgt;
        end else if (isBr && !hit && taken) begin
            e.ctr = 2'b10;
        end else if (isBr) begin
            doWrite = 1'b0;
        end
        if (hit && e.ctr == ctr && e.tgt == ptgt) doWrite = 1'b0;
        if (doWrite) expQ.push_back(e);
        if (wrong) begin
            expRedir   = 1'b1;
            expRedirPc = taken ? tgt : pc + 32'd4;
            expMis     = expMis + 32'd1;
        end
    endtask

    // Drive one resolved instruction and hold it until the DUT accepts it.
    task automatic applyStimulus(input logic [31:0] pc, input logic isBr, input logic taken,
                                 input logic [31:0] tgt, input logic hit,
                                 input logic [1:0] ctr, input logic [31:0] ptgt);
        int  waited;
        bit  done;
        waited      = 0;
        done        = 0;
        res_valid   = 1'b1;
        res_pc      = pc;
        res_is_br   = isBr;
        res_taken   = taken;
        res_target  = tgt;
        pred_hit    = hit;
        pred_ctr    = ctr;
        pred_target = ptgt;
        while (!done) begin
            @(negedge clk);
            if (res_ready) begin
                @(posedge clk);
                #1;
                recordAccepted(pc, isBr, taken, tgt, hit, ctr, ptgt);
                done = 1;
            end else begin
                waited++;
                if (waited > 50) begin
                    checkOutput("acceptTimeout", 64'(waited), 64'd0);
                    done = 1;
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        res_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (expQ.size() != 0) checkOutput("drainTimeout", 64'(expQ.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Per-cycle scoreboard comparison on the falling edge.
    always @(negedge clk) begin
        if (monOn) begin
            logic   expLoad;
            entry_t e;
            checkOutput("occupancy", 64'(occupancy), 64'(expQ.size()));
            checkOutput("resReady", 64'(res_ready), 64'(expQ.size() < 4));
            expLoad = (expQ.size() > 0) &&
                      ((setOf(expQ[0].pc) != setOf(fetch_raddr)) || waitCnt == 3);
            checkOutput("btbLoad", 64'(btb_load), 64'(expLoad));
            if (expLoad) begin
                e = expQ.pop_front();
                checkOutput("btbWaddr", 64'(btb_waddr), 64'(e.pc));
                checkOutput("btbWdata", 64'(btb_wdata), 64'({e.ctr, e.tgt}));
                waitCnt = 0;
            end else if (expQ.size() > 0) begin
                waitCnt++;
            end
            checkOutput("redirect", 64'(redirect), 64'(expRedir));
            if (expRedir && redirect)
                checkOutput("redirectPc", 64'(redirect_pc), 64'(expRedirPc));
            expRedir = 1'b0;
            checkOutput("mispredictCount", 64'(mispredict_count), 64'(expMis));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] tgts [3];
        tgts[0] = 32'h200;
        tgts[1] = 32'h300;
        tgts[2] = 32'h400;
        checkCount = 0;
        passCount  = 0;
        monOn      = 0;
        expRedir   = 1'b0;
        expRedirPc = '0;
        expMis     = '0;
        waitCnt    = 0;
        rst        = 1'b0;
        res_valid  = 1'b0;
        res_pc     = '0;
        res_is_br  = 1'b0;
        res_taken  = 1'b0;
        res_target = '0;
        pred_hit   = 1'b0;
        pred_ctr   = '0;
        pred_target = '0;
        fetch_raddr = 32'h4;

        #2;
        checkOutput("rstReady", 64'(res_ready), 64'd1);
        checkOutput("rstLoad", 64'(btb_load), 64'd0);
        checkOutput("rstOccupancy", 64'(occupancy), 64'd0);
        checkOutput("rstRedirect", 64'(redirect), 64'd0);
        checkOutput("rstRedirectPc", 64'(redirect_pc), 64'd0);
        checkOutput("rstMispredicts", 64'(mispredict_count), 64'd0);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        monOn = 1;

        $display("[TB] cold miss");
        applyStimulus(32'h100, 1, 1, 32'h200, 0, 2'b00, 32'h0);
        checkOutput("coldRedirect", 64'(redirect), 64'd1);
        checkOutput("coldRedirectPc", 64'(redirect_pc), 64'h200);
        checkOutput("coldLoad", 64'(btb_load), 64'd1);
        checkOutput("coldWdata", 64'(btb_wdata), 64'({2'b10, 32'h200}));
        waitDrain();

        $display("[TB] prediction cases");
        applyStimulus(32'h20, 1, 1, 32'h300, 1, 2'b11, 32'h300);
        checkOutput("satOccupancy", 64'(occupancy), 64'd0);
        applyStimulus(32'h40, 1, 0, 32'h0, 1, 2'b10, 32'h500);
        applyStimulus(32'h60, 0, 1, 32'h700, 0, 2'b00, 32'h0);
        applyStimulus(32'h80, 1, 1, 32'h900, 1, 2'b11, 32'h800);
        applyStimulus(32'hA0, 1, 0, 32'h0, 0, 2'b01, 32'h0);
        applyStimulus(32'hC0, 1, 1, 32'h600, 1, 2'b10, 32'h600);
        applyStimulus(32'hE0, 1, 0, 32'h0, 1, 2'b00, 32'h440);
        applyStimulus(32'hFFFF_FFFC, 1, 0, 32'h0, 1, 2'b11, 32'h10);
        waitDrain();

        $display("[TB] set conflict");
        fetch_raddr = 32'h90;
        applyStimulus(32'h10, 1, 1, 32'h80, 0, 2'b00, 32'h0);
        waitDrain();

        $display("[TB] full fifo");
        applyStimulus(32'h10, 1, 1, 32'h1000, 0, 2'b00, 32'h0);
        applyStimulus(32'h30, 0, 1, 32'h1100, 0, 2'b00, 32'h0);
        applyStimulus(32'h50, 1, 1, 32'h1200, 1, 2'b01, 32'h0);
        applyStimulus(32'h70, 1, 0, 32'h0, 1, 2'b11, 32'h1300);
        applyStimulus(32'hF0, 1, 1, 32'h1400, 0, 2'b00, 32'h0);
        applyStimulus(32'h10, 1, 1, 32'h1500, 1, 2'b10, 32'h1000);
        waitDrain();

        $display("[TB] random traffic");
        for (int i = 0; i < 40; i++) begin
            fetch_raddr = 32'($urandom_range(0, 15)) << 2;
            applyStimulus(32'($urandom_range(0, 15)) << 2, ($urandom_range(0, 4) != 0),
                          1'($urandom_range(0, 1)), tgts[$urandom_range(0, 2)],
                          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          tgts[$urandom_range(0, 2)]);
        end
        waitDrain();

        $display("[TB] async reset mid-operation");
        fetch_raddr = 32'h90;
        applyStimulus(32'h10, 1, 1, 32'h2000, 0, 2'b00, 32'h0);
        applyStimulus(32'h30, 0, 1, 32'h2100, 0, 2'b00, 32'h0);
        applyStimulus(32'h50, 1, 1, 32'h2200, 0, 2'b00, 32'h0);
        #1;
        checkOutput("preRstOccupancy", 64'(occupancy), 64'd3);
        checkOutput("preRstRedirect", 64'(redirect), 64'd1);
        monOn = 0;
        #1;
        rst = 1'b0;
        #1;
        checkOutput("asyncOccupancy", 64'(occupancy), 64'd0);
        checkOutput("asyncRedirect", 64'(redirect), 64'd0);
        checkOutput("asyncLoad", 64'(btb_load), 64'd0);
        checkOutput("asyncMispredicts", 64'(mispredict_count), 64'd0);
        expQ.delete();
        expRedir = 1'b0;
        expMis   = '0;
        waitCnt  = 0;
        @(posedge clk);
        #1;
        rst   = 1'b1;
        monOn = 1;
        fetch_raddr = 32'h4;
        applyStimulus(32'h100, 1, 1, 32'h200, 0, 2'b00, 32'h0);
        waitDrain();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
